// File: rtl/approx_mul_ha_pipe_if.sv
// Operand/product stream and event-counter access for approx_mul_ha_pipe.
// The master side drives operands, out_ready and evt_clr.
interface approx_mul_ha_pipe_if #(
   parameter int unsigned W     = 8,
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     x;
   logic [W-1:0]     y;
   logic             approx_en;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   p;
   logic [CNT_W-1:0] evt_cnt;
   logic             evt_clr;

   modport master (
      output in_valid, x, y, approx_en, out_ready, evt_clr,
      input  in_ready, out_valid, p, evt_cnt
   );

   modport slave (
      input  in_valid, x, y, approx_en, out_ready, evt_clr,
      output in_ready, out_valid, p, evt_cnt
   );
endinterface

// File: rtl/approx_mul_ha_pipe.sv
// Two-stage elastic W x W multiplier: a half-adder array over row pairs with run-time
// approximation of low columns, then a final pair sum. Counts approximated HA events.
module approx_mul_ha_pipe #(
   parameter int unsigned W     = 8,
   parameter int unsigned K     = 4,
   parameter int unsigned CNT_W = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   approx_mul_ha_pipe_if.slave bus
);
   localparam int unsigned NP = W / 2;
   localparam int unsigned PW = 2 * W;
   localparam int unsigned EW = $clog2(NP * (W - 1) + 1);
   localparam int unsigned SW = ((CNT_W > EW) ? CNT_W : EW) + 1;
   localparam logic [SW-1:0] CntMax = SW'({CNT_W{1'b1}});

   typedef logic [W:0] row_t;

   row_t [NP-1:0]  ha_t, ha_cy;
   logic [EW-1:0]  ha_ev;
   row_t [NP-1:0]  t_d, t_q, cy_d, cy_q;
   logic [EW-1:0]  ev_d, ev_q;
   logic           s1_valid_d, s1_valid_q;
   logic           out_valid_d, out_valid_q;
   logic [PW-1:0]  p_d, p_q, p_sum;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [SW-1:0]  cnt_sum;
   logic           stage1_adv, stage2_adv;

   assign stage2_adv    = !out_valid_q || bus.out_ready;
   assign stage1_adv    = !s1_valid_q || stage2_adv;
   assign bus.in_ready  = stage1_adv;
   assign bus.out_valid = out_valid_q;
   assign bus.p         = p_q;
   assign bus.evt_cnt   = cnt_q;

   // Half-adder array; an approximated cell ORs its inputs and drops the carry.
   always_comb begin
      logic a, b;
      a     = 1'b0;
      b     = 1'b0;
      ha_t  = '0;
      ha_cy = '0;
      ha_ev = '0;
      for (int j = 0; j < int'(NP); j++) begin
         ha_t[j][0] = bus.y[0] & bus.x[2*j];
         ha_t[j][W] = bus.y[W-1] & bus.x[2*j+1];
         for (int c = 1; c < int'(W); c++) begin
            a = bus.y[c] & bus.x[2*j];
            b = bus.y[c-1] & bus.x[2*j+1];
            if (bus.approx_en && (2 * j + c < int'(K))) begin
               ha_t[j][c] = a | b;
               ha_ev      = ha_ev + EW'(a & b);
            end else begin
               ha_t[j][c]    = a ^ b;
               ha_cy[j][c+1] = a & b;
            end
         end
      end
   end

   always_comb begin
      p_sum = '0;
      for (int j = 0; j < int'(NP); j++) begin
         p_sum = p_sum + (PW'(t_q[j]) << (2 * j)) + (PW'(cy_q[j]) << (2 * j));
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      t_d         = t_q;
      cy_d        = cy_q;
      ev_d        = ev_q;
      out_valid_d = out_valid_q;
      p_d         = p_q;
      cnt_d       = cnt_q;
      cnt_sum     = SW'(cnt_q) + SW'(ev_q);

      if (stage1_adv) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            t_d  = ha_t;
            cy_d = ha_cy;
            ev_d = ha_ev;
         end
      end

      if (stage2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) p_d = p_sum;
      end

      // Clear wins; the event count of a beat advancing in the same cycle is dropped.
      if (bus.evt_clr) begin
         cnt_d = '0;
      end else if (stage2_adv && s1_valid_q) begin
         cnt_d = (cnt_sum > CntMax) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         t_q         <= '0;
         cy_q        <= '0;
         ev_q        <= '0;
         out_valid_q <= 1'b0;
         p_q         <= '0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         t_q         <= t_d;
         cy_q        <= cy_d;
         ev_q        <= ev_d;
         out_valid_q <= out_valid_d;
         p_q         <= p_d;
         cnt_q       <= cnt_d;
      end
   end
endmodule
